tx_vc_router: RTL and testbench

Parametrised transmit-side router for the link layer. Incoming words are steered into one of `NUM_VC` virtual-channel queues by their VC-ID field. An arbiter then moves at most one word per cycle from a VC head into one of `NUM_DEST` destination queues, selected by the word's destination field. Per-destination almost-full backpressure stops the arbiter. Storage is internal; the block sits between the transmit input and the per-destination egress consumers.

---
 rtl/tx_vc_router.sv | 171 +++++++++++++++++
 tb/tb_tx_vc_router.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_vc_router.sv
// Transmit-side virtual-channel router.
// Ingress words are sorted into per-VC queues by VC-ID. A one-grant-per-cycle
// arbiter moves VC heads into per-destination queues, stalling a VC whose head
// targets a destination at or above its almost-full threshold. Each destination
// queue is popped independently into a registered output slice.
module tx_vc_router #(
   parameter int DATA_W     = 6,
   parameter int NUM_VC     = 2,
   parameter int NUM_DEST   = 2,
   parameter int VC_DEPTH   = 16,
   parameter int DEST_DEPTH = 4,
   parameter int DEST_HIGH  = 3,
   parameter int ARB_MODE   = 0
) (
   input  logic                         clk,
   input  logic                         RESET,
   input  logic                         push_in,
   input  logic [DATA_W-1:0]            data_in,
   input  logic [NUM_DEST-1:0]          pop_d,
   output logic [NUM_DEST*DATA_W-1:0]   data_out,
   output logic [NUM_DEST-1:0]          valid_d,
   output logic [NUM_DEST-1:0]          empty_d,
   output logic [NUM_VC-1:0]            vc_empty,
   output logic [NUM_DEST-1:0]          pause_d,
   output logic                         err_ovf,
   output logic                         err_unf,
   output logic                         idle
);

   localparam int VC_BITS   = $clog2(NUM_VC);
   localparam int DEST_BITS = $clog2(NUM_DEST);
   localparam int VP        = $clog2(VC_DEPTH);
   localparam int VCW       = $clog2(VC_DEPTH + 1);
   localparam int DP        = $clog2(DEST_DEPTH);
   localparam int DCW       = $clog2(DEST_DEPTH + 1);

   logic [DATA_W-1:0]    vc_mem  [NUM_VC][VC_DEPTH];
   logic [VP-1:0]        vc_rd   [NUM_VC];
   logic [VP-1:0]        vc_wr   [NUM_VC];
   logic [VCW-1:0]       vc_cnt  [NUM_VC];
   logic [DATA_W-1:0]    dst_mem [NUM_DEST][DEST_DEPTH];
   logic [DP-1:0]        dst_rd  [NUM_DEST];
   logic [DP-1:0]        dst_wr  [NUM_DEST];
   logic [DCW-1:0]       dst_cnt [NUM_DEST];

   logic [VC_BITS-1:0]   rr_ptr;
   logic [VC_BITS-1:0]   push_vc;
   logic [VC_BITS-1:0]   gnt_vc;
   logic [VC_BITS-1:0]   idx;
   logic                 push_ok;
   logic                 gnt_valid;
   logic [NUM_VC-1:0]    elig;
   logic [NUM_VC-1:0]    vc_inc;
   logic [NUM_VC-1:0]    vc_dec;
   logic [NUM_DEST-1:0]  dst_inc;
   logic [NUM_DEST-1:0]  dst_dec;
   logic [DATA_W-1:0]    gnt_data;
   logic [DEST_BITS-1:0] gnt_dest;

   // A push is judged against the count at the start of the cycle only,
   // so a same-cycle grant out of a full queue does not make room.
   assign push_vc = data_in[DATA_W-1 -: VC_BITS];
   assign push_ok = push_in && (vc_cnt[push_vc] != VCW'(VC_DEPTH));

   // Status flags decoded from registered counts.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++)
         vc_empty[v] = (vc_cnt[v] == '0);
      for (int d = 0; d < NUM_DEST; d++) begin
         empty_d[d] = (dst_cnt[d] == '0);
         pause_d[d] = (dst_cnt[d] >= DCW'(DEST_HIGH));
      end
      idle = (&vc_empty) && (&empty_d);
   end

   // A VC may compete only if its head word's destination is not paused.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++)
         elig[v] = (vc_cnt[v] != '0) &&
                   !pause_d[vc_mem[v][vc_rd[v]][DATA_W-1-VC_BITS -: DEST_BITS]];
   end

   // Arbiter: scan from VC0 (strict) or from the round-robin pointer.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_vc    = '0;
      idx       = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         idx = (ARB_MODE == 1) ? rr_ptr + VC_BITS'(i) : VC_BITS'(i);
         if (!gnt_valid && elig[idx]) begin
            gnt_valid = 1'b1;
            gnt_vc    = idx;
         end
      end
      gnt_data = vc_mem[gnt_vc][vc_rd[gnt_vc]];
      gnt_dest = gnt_data[DATA_W-1-VC_BITS -: DEST_BITS];
   end

   // Per-queue increment/decrement strobes.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         vc_inc[v] = push_ok && (push_vc == VC_BITS'(v));
         vc_dec[v] = gnt_valid && (gnt_vc == VC_BITS'(v));
      end
      for (int d = 0; d < NUM_DEST; d++) begin
         dst_inc[d] = gnt_valid && (gnt_dest == DEST_BITS'(d));
         dst_dec[d] = pop_d[d] && (dst_cnt[d] != '0);
      end
   end

   // Queue storage; contents need no reset since pointers gate every read.
   always_ff @(posedge clk) begin
      if (push_ok)
         vc_mem[push_vc][vc_wr[push_vc]] <= data_in;
      if (gnt_valid)
         dst_mem[gnt_dest][dst_wr[gnt_dest]] <= gnt_data;
   end

   // Pointers, counts, egress registers, error flags and round-robin pointer.
   always_ff @(posedge clk) begin
      if (RESET) begin
         for (int v = 0; v < NUM_VC; v++) begin
            vc_rd[v]  <= '0;
            vc_wr[v]  <= '0;
            vc_cnt[v] <= '0;
         end
         for (int d = 0; d < NUM_DEST; d++) begin
            dst_rd[d]  <= '0;
            dst_wr[d]  <= '0;
            dst_cnt[d] <= '0;
         end
         data_out <= '0;
         valid_d  <= '0;
         err_ovf  <= 1'b0;
         err_unf  <= 1'b0;
         rr_ptr   <= '0;
      end else begin
         if (push_in && !push_ok)
            err_ovf <= 1'b1;
         if (gnt_valid)
            rr_ptr <= gnt_vc + VC_BITS'(1);
         for (int v = 0; v < NUM_VC; v++) begin
            if (vc_inc[v])
               vc_wr[v] <= vc_wr[v] + VP'(1);
            if (vc_dec[v])
               vc_rd[v] <= vc_rd[v] + VP'(1);
            if (vc_inc[v] && !vc_dec[v])
               vc_cnt[v] <= vc_cnt[v] + VCW'(1);
            else if (vc_dec[v] && !vc_inc[v])
               vc_cnt[v] <= vc_cnt[v] - VCW'(1);
         end
         valid_d <= '0;
         for (int d = 0; d < NUM_DEST; d++) begin
            if (dst_inc[d])
               dst_wr[d] <= dst_wr[d] + DP'(1);
            if (dst_dec[d]) begin
               dst_rd[d] <= dst_rd[d] + DP'(1);
               data_out[d*DATA_W +: DATA_W] <= dst_mem[d][dst_rd[d]];
               valid_d[d] <= 1'b1;
            end else if (pop_d[d]) begin
               err_unf <= 1'b1;
            end
            if (dst_inc[d] && !dst_dec[d])
               dst_cnt[d] <= dst_cnt[d] + DCW'(1);
            else if (dst_dec[d] && !dst_inc[d])
               dst_cnt[d] <= dst_cnt[d] - DCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_tx_vc_router.sv
// Scoreboard bench for tx_vc_router: two instances (strict priority and
// round-robin) share one stimulus stream; expected egress words are queued per
// instance and destination, and a negedge monitor pops and compares them.
module tb_tx_vc_router;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        push_in = 1'b0;
   logic [5:0]  data_in = '0;
   logic [1:0]  pop_d = '0;

   logic [11:0] data_out0, data_out1;
   logic [1:0]  valid0, valid1, empty0, empty1, vce0, vce1, pause0, pause1;
   logic        ovf0, ovf1, unf0, unf1, idle0, idle1;

   int checks = 0;
   int errors = 0;

   logic [5:0] q00[$];
   logic [5:0] q01[$];
   logic [5:0] q10[$];
   logic [5:0] q11[$];

   tx_vc_router #(.ARB_MODE(0)) dut0 (
      .clk(clk), .RESET(RESET), .push_in(push_in), .data_in(data_in), .pop_d(pop_d),
      .data_out(data_out0), .valid_d(valid0), .empty_d(empty0), .vc_empty(vce0),
      .pause_d(pause0), .err_ovf(ovf0), .err_unf(unf0), .idle(idle0));

   tx_vc_router #(.ARB_MODE(1)) dut1 (
      .clk(clk), .RESET(RESET), .push_in(push_in), .data_in(data_in), .pop_d(pop_d),
      .data_out(data_out1), .valid_d(valid1), .empty_d(empty1), .vc_empty(vce1),
      .pause_d(pause1), .err_ovf(ovf1), .err_unf(unf1), .idle(idle1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk2(input string name, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] exp);
      chk({name, "_m0"}, a0, exp);
      chk({name, "_m1"}, a1, exp);
   endtask

   task automatic exp_m(input int m, input logic [5:0] v);
      // destination is bit 4 for this configuration
      case ({m[0], v[4]})
         2'b00: q00.push_back(v);
         2'b01: q01.push_back(v);
         2'b10: q10.push_back(v);
         default: q11.push_back(v);
      endcase
   endtask

   task automatic exp_both(input logic [5:0] v);
      exp_m(0, v);
      exp_m(1, v);
   endtask

   task automatic mon(input int m, input int d, input logic [5:0] act);
      logic [5:0] e;
      logic       have;
      have = 1'b0;
      e    = '0;
      case ({m[0], d[0]})
         2'b00: if (q00.size() > 0) begin e = q00.pop_front(); have = 1'b1; end
         2'b01: if (q01.size() > 0) begin e = q01.pop_front(); have = 1'b1; end
         2'b10: if (q10.size() > 0) begin e = q10.pop_front(); have = 1'b1; end
         default: if (q11.size() > 0) begin e = q11.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL egress_m%0d_d%0d unexpected word actual=%0h required=none", m, d, act);
      end else if (act !== e) begin
         errors++;
         $display("FAIL egress_m%0d_d%0d actual=%0h required=%0h", m, d, act, e);
      end
   endtask

   always @(negedge clk) begin
      if (valid0[0]) mon(0, 0, data_out0[5:0]);
      if (valid0[1]) mon(0, 1, data_out0[11:6]);
      if (valid1[0]) mon(1, 0, data_out1[5:0]);
      if (valid1[1]) mon(1, 1, data_out1[11:6]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      q00.delete(); q01.delete(); q10.delete(); q11.delete();
   endtask

   task automatic do_reset();
      RESET = 1'b1; push_in = 1'b0; pop_d = '0;
      tick();
      flush();
      RESET = 1'b0;
   endtask

   task automatic check_rst(input string tag);
      chk2({tag, "_data_out"}, data_out0, data_out1, 0);
      chk2({tag, "_valid_d"},  valid0, valid1, 0);
      chk2({tag, "_empty_d"},  empty0, empty1, 2'b11);
      chk2({tag, "_vc_empty"}, vce0, vce1, 2'b11);
      chk2({tag, "_pause_d"},  pause0, pause1, 0);
      chk2({tag, "_err_ovf"},  ovf0, ovf1, 0);
      chk2({tag, "_err_unf"},  unf0, unf1, 0);
      chk2({tag, "_idle"},     idle0, idle1, 1);
   endtask

   task automatic push(input logic [5:0] v, input bit do_exp);
      push_in = 1'b1;
      data_in = v;
      if (do_exp) exp_both(v);
      tick();
      push_in = 1'b0;
   endtask

   task automatic drain(input int n);
      pop_d = 2'b11;
      repeat (n) tick();
      pop_d = 2'b00;
   endtask

   task automatic basic(input string tag);
      push_in = 1'b1; data_in = 6'h05; exp_both(6'h05);
      tick();
      chk2({tag, "_vc_empty_n"}, vce0, vce1, 2'b10);
      chk2({tag, "_idle_n"}, idle0, idle1, 0);
      data_in = 6'h3A; exp_both(6'h3A);
      tick();
      chk2({tag, "_empty_d_n1"}, empty0, empty1, 2'b10);
      chk2({tag, "_vc_empty_n1"}, vce0, vce1, 2'b01);
      push_in = 1'b0; pop_d = 2'b01;
      tick();
      chk2({tag, "_valid_n2"}, valid0, valid1, 2'b01);
      chk2({tag, "_d0_n2"}, data_out0[5:0], data_out1[5:0], 6'h05);
      pop_d = 2'b10;
      tick();
      chk2({tag, "_valid_n3"}, valid0, valid1, 2'b10);
      chk2({tag, "_d1_n3"}, data_out0[11:6], data_out1[11:6], 6'h3A);
      pop_d = 2'b00;
      tick();
      chk2({tag, "_idle_end"}, idle0, idle1, 1);
      chk2({tag, "_valid_end"}, valid0, valid1, 0);
   endtask

   task automatic fill_pause();
      push(6'h21, 1); push(6'h31, 1); push(6'h22, 1);
      push(6'h32, 1); push(6'h23, 1); push(6'h33, 1);
   endtask

   initial begin
      tick(); tick();
      flush();
      RESET = 1'b0;
      check_rst("por");

      basic("basic");

      // underflow on an empty destination after reset
      do_reset();
      pop_d = 2'b10;
      tick();
      pop_d = 2'b00;
      chk2("unf_valid", valid0, valid1, 0);
      chk2("unf_slice1", data_out0[11:6], data_out1[11:6], 0);
      chk2("unf_flag", unf0, unf1, 1);
      chk2("unf_ovf_clear", ovf0, ovf1, 0);
      repeat (3) tick();
      chk2("unf_sticky", unf0, unf1, 1);

      // reset mid-stream with push and pop active
      push(6'h31, 1); push(6'h32, 1); push(6'h33, 1); push(6'h34, 1);
      chk2("mid_pause", pause0, pause1, 2'b10);
      pop_d = 2'b10;
      push(6'h35, 1);
      pop_d = 2'b00;
      chk2("mid_popped", data_out0[11:6], data_out1[11:6], 6'h31);
      RESET = 1'b1; push_in = 1'b1; data_in = 6'h07; pop_d = 2'b10;
      tick();
      RESET = 1'b0; push_in = 1'b0; pop_d = 2'b00;
      flush();
      check_rst("mid");
      basic("basic2");

      // backpressure on D0
      do_reset();
      for (int i = 1; i <= 6; i++) push(6'(i), 1);
      repeat (3) tick();
      chk2("bp_pause", pause0, pause1, 2'b01);
      chk2("bp_vc_held", vce0, vce1, 2'b10);
      chk2("bp_empty_d", empty0, empty1, 2'b10);
      pop_d = 2'b01;
      tick();
      pop_d = 2'b00;
      chk2("bp_after_pop", pause0, pause1, 2'b00);
      tick();
      chk2("bp_resumed", pause0, pause1, 2'b01);
      drain(12);
      chk2("bp_idle", idle0, idle1, 1);

      // arbitration order, both modes
      do_reset();
      fill_pause();
      push(6'h01, 0); push(6'h24, 0); push(6'h11, 0); push(6'h34, 0);
      push(6'h02, 0); push(6'h25, 0); push(6'h12, 0); push(6'h35, 0);
      exp_m(0, 6'h01); exp_m(0, 6'h11); exp_m(0, 6'h02); exp_m(0, 6'h12);
      exp_m(0, 6'h24); exp_m(0, 6'h34); exp_m(0, 6'h25); exp_m(0, 6'h35);
      exp_m(1, 6'h01); exp_m(1, 6'h24); exp_m(1, 6'h11); exp_m(1, 6'h34);
      exp_m(1, 6'h02); exp_m(1, 6'h25); exp_m(1, 6'h12); exp_m(1, 6'h35);
      tick(); tick();
      chk2("arb_paused", pause0, pause1, 2'b11);
      drain(20);
      chk2("arb_idle", idle0, idle1, 1);

      // overflow of VC0 while both destinations are paused
      do_reset();
      fill_pause();
      for (int i = 0; i < 16; i++) push(6'(i), 1);
      chk2("ovf_before", ovf0, ovf1, 0);
      push(6'h10, 0);
      chk2("ovf_set", ovf0, ovf1, 1);
      chk2("ovf_vc_empty", vce0, vce1, 2'b10);
      drain(30);
      chk2("ovf_sticky", ovf0, ovf1, 1);
      chk2("ovf_idle", idle0, idle1, 1);

      tick();
      chk("sb_m0_d0_left", q00.size(), 0);
      chk("sb_m0_d1_left", q01.size(), 0);
      chk("sb_m1_d0_left", q10.size(), 0);
      chk("sb_m1_d1_left", q11.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
